// File: rtl/calc_pkg.sv
// calc_pkg: shared constants and types for the binary-neural-network neuron
// accumulator.
//   CALC_ALU_WIDTH : default accumulator width (two's-complement signed)
//   calc_op_e      : per-cycle accumulator operation decoded from the inputs
// The activation threshold is "strictly greater than zero"; calc applies it
// as sign bit clear and value non-zero.
package calc_pkg;

    localparam int CALC_ALU_WIDTH = 12;

    typedef enum logic [1:0] {
        CALC_OP_CLEAR = 2'd0,
        CALC_OP_HOLD  = 2'd1,
        CALC_OP_INC   = 2'd2,
        CALC_OP_DEC   = 2'd3
    } calc_op_e;

endpackage : calc_pkg

// File: rtl/calc.sv
// calc: BNN neuron accumulator. On each rising edge it adds one for agreement
// (calc_in=0) or subtracts one for disagreement (calc_in=1). The running score
// saturates at the signed limits of alu_width.
// Ports:
//   clk           : clock, state changes on the rising edge
//   rst           : synchronous active-high clear, overrides everything else
//   calc_1        : accumulate enable (0 holds the score)
//   calc_in       : weight XOR activation bit (0 agree, 1 disagree)
//   agg_out2alu   : current signed score
//   agg_out_acted : 1 when the score is strictly positive
module calc
    import calc_pkg::*;
#(
    parameter int alu_width = CALC_ALU_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        calc_1,
    input  logic                        calc_in,
    output logic signed [alu_width-1:0] agg_out2alu,
    output logic                        agg_out_acted
);

    // Saturation limits as bit patterns: 0111..1 and 1000..0.
    localparam logic signed [alu_width-1:0] ACC_MAX = {1'b0, {(alu_width-1){1'b1}}};
    localparam logic signed [alu_width-1:0] ACC_MIN = {1'b1, {(alu_width-1){1'b0}}};
    localparam logic signed [alu_width-1:0] ACC_ONE = {{(alu_width-1){1'b0}}, 1'b1};
    localparam logic signed [alu_width-1:0] ACC_ZERO = {alu_width{1'b0}};

    logic signed [alu_width-1:0] acc_r;
    logic signed [alu_width-1:0] acc_next_s;
    calc_op_e                    op_s;

    // Decode the inputs into a single operation in priority order.
    always_comb begin
        op_s = CALC_OP_HOLD;
        if (rst) begin
            op_s = CALC_OP_CLEAR;
        end else if (!calc_1) begin
            op_s = CALC_OP_HOLD;
        end else if (calc_in) begin
            op_s = CALC_OP_DEC;
        end else begin
            op_s = CALC_OP_INC;
        end
    end

    // Next score; explicit limit compares keep the value from wrapping.
    always_comb begin
        acc_next_s = acc_r;
        case (op_s)
            CALC_OP_CLEAR: acc_next_s = ACC_ZERO;
            CALC_OP_HOLD:  acc_next_s = acc_r;
            CALC_OP_INC: begin
                if (acc_r == ACC_MAX) begin
                    acc_next_s = acc_r;
                end else begin
                    acc_next_s = acc_r + ACC_ONE;
                end
            end
            CALC_OP_DEC: begin
                if (acc_r == ACC_MIN) begin
                    acc_next_s = acc_r;
                end else begin
                    acc_next_s = acc_r - ACC_ONE;
                end
            end
            default:       acc_next_s = ACC_ZERO;
        endcase
    end

    // Score register; the clear is folded into acc_next_s so rst stays synchronous.
    always_ff @(posedge clk) begin
        acc_r <= acc_next_s;
    end

    // The score is exposed straight from the register; activation is decoded
    // from it so the controller sees it on the same edge it pulses rst.
    always_comb begin
        agg_out2alu   = acc_r;
        agg_out_acted = (!acc_r[alu_width-1]) && (acc_r != ACC_ZERO);
    end

endmodule : calc

// File: tb/tb_calc.sv
// tb_calc: self-checking bench for calc. A behavioural model tracks the score
// as a plain integer clamped to [-2048, 2047]; a compare process checks the
// DUT against it on every falling edge once the first reset has been applied.
// Directed sequences additionally pin both DUT and model to literal values.
module tb_calc;

    localparam int W = 12;
    localparam int MAXV = 2047;
    localparam int MINV = -2048;

    logic                clk;
    logic                rst;
    logic                calc_1;
    logic                calc_in;
    logic signed [W-1:0] agg_out2alu;
    logic                agg_out_acted;

    int checks;
    int errors;
    int m_score;
    bit m_valid;

    calc #(.alu_width(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .calc_1       (calc_1),
        .calc_in      (calc_in),
        .agg_out2alu  (agg_out2alu),
        .agg_out_acted(agg_out_acted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: reset clears, disabled holds, otherwise +/-1 clamped to range.
    function automatic int model_next(input int s, input logic r, input logic e, input logic b);
        int n;
        if (r) n = 0;
        else if (!e) n = s;
        else if (b) n = (s - 1 < MINV) ? MINV : s - 1;
        else n = (s + 1 > MAXV) ? MAXV : s + 1;
        return n;
    endfunction

    always @(posedge clk) begin
        m_score <= model_next(m_score, rst, calc_1, calc_in);
        if (rst) m_valid <= 1'b1;
    end

    // Every-cycle comparison of DUT against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            logic [W-1:0] ev;
            logic         ea;
            ev = m_score[W-1:0];
            ea = (m_score > 0);
            checks++;
            if (agg_out2alu !== ev || agg_out_acted !== ea) begin
                errors++;
                $display("FAIL model_cmp t=%0t score got %0d want %0d acted got %b want %b",
                         $time, agg_out2alu, $signed(ev), agg_out_acted, ea);
            end
        end
    end

    task automatic drive(input logic r, input logic e, input logic b);
        rst = r;
        calc_1 = e;
        calc_in = b;
        @(posedge clk);
        #1;
    endtask

    // Literal expectation checked against both the DUT and the model.
    task automatic check_lit(input string name, input logic [W-1:0] ev, input logic ea);
        logic [W-1:0] mv;
        mv = m_score[W-1:0];
        checks++;
        if (agg_out2alu !== ev || agg_out_acted !== ea) begin
            errors++;
            $display("FAIL %s dut score got 0x%03h want 0x%03h acted got %b want %b",
                     name, agg_out2alu, ev, agg_out_acted, ea);
        end
        checks++;
        if (mv !== ev || (m_score > 0) != ea) begin
            errors++;
            $display("FAIL %s_model score got 0x%03h want 0x%03h", name, mv, ev);
        end
    endtask

    initial begin
        logic [W-1:0] dis_exp [6];
        logic         dis_in  [6];
        checks = 0;
        errors = 0;
        m_valid = 1'b0;
        m_score = 0;
        rst = 1'b0;
        calc_1 = 1'b1;
        calc_in = 1'b0;
        @(negedge clk);

        // Reset held two cycles with an agreement bit present.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            check_lit("reset", 12'h000, 1'b0);
        end

        // Agreement run.
        for (int i = 0; i < 5; i++) begin
            logic [W-1:0] e;
            e = W'(i + 1);
            drive(1'b0, 1'b1, 1'b0);
            check_lit("agree", e, 1'b1);
        end

        // Disagreement then back to a tie.
        dis_exp = '{12'hFFF, 12'hFFE, 12'hFFD, 12'hFFE, 12'hFFF, 12'h000};
        dis_in  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        drive(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, dis_in[i]);
            check_lit("disagree_tie", dis_exp[i], 1'b0);
        end

        // Saturation at both ends.
        drive(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2100; i++) drive(1'b0, 1'b1, 1'b0);
        check_lit("sat_max", 12'h7FF, 1'b1);
        for (int i = 0; i < 4200; i++) drive(1'b0, 1'b1, 1'b1);
        check_lit("sat_min", 12'h800, 1'b0);

        // Enable low holds the score regardless of calc_in.
        drive(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0);
        check_lit("hold_start", 12'h003, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, i[0]);
            check_lit("hold", 12'h003, 1'b1);
        end

        // Mid-operation reset discards the score and its own calc_in bit.
        drive(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 1'b0);
        check_lit("midop_pre", 12'h007, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        check_lit("midop_rst", 12'h000, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        check_lit("midop_post", 12'h001, 1'b1);

        // Randomized traffic with biased runs so both limits get visited.
        for (int blk = 0; blk < 40; blk++) begin
            int bias;
            bias = $urandom_range(0, 2);
            for (int i = 0; i < 120; i++) begin
                logic r, e, b;
                r = ($urandom_range(0, 199) == 0);
                e = ($urandom_range(0, 7) != 0);
                if (bias == 0) b = ($urandom_range(0, 15) == 0);
                else if (bias == 1) b = ($urandom_range(0, 15) != 0);
                else b = $urandom_range(0, 1);
                drive(r, e, b);
            end
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_calc
